fft_8_seq: RTL and testbench
============================

FFT_8_SEQ -- requirements
Module: fft_8_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed sample width per real/imag component.
REQ-002 SHALL have parameter TIMEOUT, default 15, max RUN cycles waiting for fft_ready.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  one clock; reset is synchronous and active-high.
REQ-005 SHALL have port abort  input  1  drop current frame, return to CLR.
REQ-006 SHALL have ports in_valid/in_ready  input/output  1/1  sample-in handshake.
REQ-007 SHALL have ports in_re, in_im  input  DATA_W each  signed input sample.
REQ-008 SHALL have ports out_valid/out_ready  output/input  1/1  result-out handshake.
REQ-009 SHALL have ports out_re, out_im  output  DATA_W each; out_idx  output  3  bin index; out_last  output  1  beat 7.
REQ-010 SHALL have ports fft_rst_n, fft_write, fft_start  output  1 each  core controls.
REQ-011 SHALL have ports fft_in_re, fft_in_im  output  8*DATA_W each  slot k at bits [k*DATA_W +: DATA_W], k=0..7.
REQ-012 SHALL have ports fft_ready  input  1; fft_out_re, fft_out_im  input  8*DATA_W each, same packing.
REQ-013 SHALL have ports busy  output  1; err_timeout  output  1 sticky; frame_cnt  output  16.

Function
REQ-014 SHALL implement FSM CLR -> LOAD -> WR -> RUN -> DRAIN -> CLR.
REQ-015 CLR: fft_rst_n=0 exactly one cycle (clears core's sticky ready), then LOAD.
REQ-016 LOAD: in_ready=1; each in_valid&in_ready beat stores sample into slot cnt, cnt 0..7; beat with cnt=7 -> WR.
REQ-017 WR: fft_write=1 for one cycle, fft_in_* driven from input buffer; -> RUN.
REQ-018 RUN: fft_start held 1; edge where fft_ready=1 captures fft_out_* into output buffer, -> DRAIN.
REQ-019 RUN timeout: fft_ready still 0 after TIMEOUT RUN cycles -> err_timeout<=1, frame dropped, no out_valid, -> CLR.
REQ-020 DRAIN: out_valid=1, out_re/out_im = output slot out_idx, out_idx 0..7 ascending; advance only on out_valid&out_ready; out_last=1 when out_idx=7; beat 7 accepted -> frame_cnt+1 (wraps 0xFFFF->0), -> CLR.
REQ-021 out_re/out_im/out_idx SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 in_ready SHALL be 0 in every state except LOAD; no overlap of load and drain.
REQ-023 Latency: first out_valid in the cycle after fft_ready sampled 1; WR immediately follows 8th input beat.
REQ-024 abort SHALL force CLR next cycle from any state, discarding buffers' frame; abort wins over a same-cycle in beat or out beat (neither counted as transferred).
REQ-025 busy=1 in WR, RUN, DRAIN; 0 in CLR, LOAD.
REQ-026 All data passthrough, no arithmetic; frame_cnt unsigned modulo 2^16.
REQ-027 fft_write and fft_start SHALL never be 1 in the same cycle.

Reset
REQ-028 RST=1 -> state CLR, cnt=0, out_idx=0, in_ready=0, out_valid=0, out_last=0, fft_write=0, fft_start=0, fft_rst_n=0, busy=0, err_timeout=0, frame_cnt=0, buffers 0.
REQ-029 RST mid-frame (any state) SHALL abandon frame with no out_valid beat after release; err_timeout cleared only by RST.

Structure
REQ-030 Package fft_seq_pkg SHALL hold state enum, DATA_W default, N_PTS=8, TIMEOUT default.
REQ-031 Sub-module fft_frame_buf (8-slot DATA_W complex register file, indexed write, flat read) SHALL be instantiated twice: input and output buffer.

Verification
REQ-032 Impulse: in_re=100 slot 0, all else 0, with real fft_8 -> 8 beats out_re=100, out_im=0, out_last on beat 7, frame_cnt=1.
REQ-033 DC: in_re=10 all slots, in_im=0 -> beat 0 out_re=80, beats 1-7 out_re=0, out_im=0.
REQ-034 Stub core fft_ready stuck 0 -> err_timeout=1 after 15 RUN cycles, no out_valid, fft_rst_n low 1 cycle, in_ready=1 again.
REQ-035 out_ready toggled 0/1 each cycle during DRAIN -> each beat held while stalled, 8 beats total, order 0..7 unchanged.
REQ-036 abort asserted with in_valid on 5th input beat -> no beat accepted, CLR, next full frame processed correctly.
REQ-037 RST pulsed during DRAIN beat 3 -> all outputs at reset values next cycle, no further out_valid until a new 8-sample frame completes.

Source files
------------

// File: rtl/fft_seq_pkg.sv
// Shared types and defaults for the 8-point FFT frame sequencer.
package fft_seq_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int N_PTS       = 8;
  localparam int IDX_W       = 3;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_LOAD,
    ST_WR,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // The sequencer reports busy while a frame is owned by the core or being drained.
  function automatic logic is_busy(input state_e s);
    return (s == ST_WR) || (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// Eight-slot complex sample register file: indexed single-slot write,
// whole-frame parallel load, flat packed read (slot k at [k*DATA_W +: DATA_W]).
module fft_frame_buf
  import fft_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    CLK,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_W-1:0]       wr_re,
  input  logic [DATA_W-1:0]       wr_im,
  input  logic                    ld_en,
  input  logic [N_PTS*DATA_W-1:0] ld_re,
  input  logic [N_PTS*DATA_W-1:0] ld_im,
  output logic [N_PTS*DATA_W-1:0] rd_re,
  output logic [N_PTS*DATA_W-1:0] rd_im
);

  logic [N_PTS*DATA_W-1:0] re_q, re_d;
  logic [N_PTS*DATA_W-1:0] im_q, im_d;

  // Next buffer contents: a full-frame load takes priority over a single-slot write.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    re_d = re_q;
    im_d = im_q;
    if (ld_en) begin
      re_d = ld_re;
      im_d = ld_im;
    end else if (wr_en) begin
      re_d[wr_idx*DATA_W +: DATA_W] = wr_re;
      im_d[wr_idx*DATA_W +: DATA_W] = wr_im;
    end
  end

  // Storage update with synchronous clear.
  always_ff @(posedge CLK) begin
    // NOTE: the storage is cleared on reset because its contents are visible on
    // output ports; a discarded frame must not leak into the next one.
    if (clr) begin
      re_q <= '0;
      im_q <= '0;
    end else begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign rd_re = re_q;
  assign rd_im = im_q;

endmodule

// File: rtl/fft_8_seq.sv
// Frame sequencer around an external 8-point FFT core: collects 8 input
// samples, hands them to the core, waits for the result and streams the 8
// bins out in ascending order. Pure data movement, no arithmetic.
module fft_8_seq
  import fft_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_re,
  input  logic [DATA_W-1:0]       in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_re,
  output logic [DATA_W-1:0]       out_im,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    fft_rst_n,
  output logic                    fft_write,
  output logic                    fft_start,
  output logic [N_PTS*DATA_W-1:0] fft_in_re,
  output logic [N_PTS*DATA_W-1:0] fft_in_im,
  input  logic                    fft_ready,
  input  logic [N_PTS*DATA_W-1:0] fft_out_re,
  input  logic [N_PTS*DATA_W-1:0] fft_out_im,
  output logic                    busy,
  output logic                    err_timeout,
  output logic [15:0]             frame_cnt
);

  localparam int RUN_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic               err_q, err_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic in_ready_q, out_valid_q, out_last_q;
  logic fft_write_q, fft_start_q, fft_rst_n_q, busy_q;

  logic                    in_beat, out_beat, out_load, buf_clr;
  logic [N_PTS*DATA_W-1:0] out_buf_re, out_buf_im;

  // Transfers are suppressed by abort so an aborted beat never lands in a buffer.
  always_comb begin
    in_beat  = in_valid && in_ready_q && !abort;
    out_beat = out_valid_q && out_ready && !abort;
    out_load = (state_q == ST_RUN) && fft_ready && !abort;
    buf_clr  = RST || abort;
  end

  fft_frame_buf #(.DATA_W(DATA_W)) u_in_buf (
    .CLK    (CLK),
    .clr    (buf_clr),
    .wr_en  (in_beat),
    .wr_idx (cnt_q),
    .wr_re  (in_re),
    .wr_im  (in_im),
    .ld_en  (1'b0),
    .ld_re  ('0),
    .ld_im  ('0),
    .rd_re  (fft_in_re),
    .rd_im  (fft_in_im)
  );

  fft_frame_buf #(.DATA_W(DATA_W)) u_out_buf (
    .CLK    (CLK),
    .clr    (buf_clr),
    .wr_en  (1'b0),
    .wr_idx ('0),
    .wr_re  ('0),
    .wr_im  ('0),
    .ld_en  (out_load),
    .ld_re  (fft_out_re),
    .ld_im  (fft_out_im),
    .rd_re  (out_buf_re),
    .rd_im  (out_buf_im)
  );

  // Frame sequencing: next state, counters and sticky timeout flag.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_idx_d   = out_idx_q;
    run_cnt_d   = run_cnt_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    if (abort) begin
      state_d   = ST_CLR;
      cnt_d     = '0;
      out_idx_d = '0;
      run_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_CLR: begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          out_idx_d = '0;
          run_cnt_d = '0;
        end
        ST_LOAD: begin
          if (in_beat) begin
            if (cnt_q == LAST_IDX) begin
              state_d = ST_WR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + IDX_W'(1);
            end
          end
        end
        ST_WR: begin
          state_d   = ST_RUN;
          run_cnt_d = '0;
        end
        ST_RUN: begin
          if (fft_ready) begin
            state_d   = ST_DRAIN;
            out_idx_d = '0;
          end else if (run_cnt_q == RUN_W'(TIMEOUT - 1)) begin
            state_d = ST_CLR;
            err_d   = 1'b1;
          end else begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
          end
        end
        ST_DRAIN: begin
          if (out_beat) begin
            if (out_idx_q == LAST_IDX) begin
              state_d     = ST_CLR;
              out_idx_d   = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              out_idx_d = out_idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = ST_CLR;
      endcase
    end
  end

  // State, counters and registered control outputs decoded from the next state.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (RST) begin
      state_q     <= ST_CLR;
      cnt_q       <= '0;
      out_idx_q   <= '0;
      run_cnt_q   <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      fft_write_q <= 1'b0;
      fft_start_q <= 1'b0;
      fft_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_idx_q   <= out_idx_d;
      run_cnt_q   <= run_cnt_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      in_ready_q  <= (state_d == ST_LOAD);
      out_valid_q <= (state_d == ST_DRAIN);
      out_last_q  <= (state_d == ST_DRAIN) && (out_idx_d == LAST_IDX);
      fft_write_q <= (state_d == ST_WR);
      fft_start_q <= (state_d == ST_RUN);
      fft_rst_n_q <= (state_d != ST_CLR);
      busy_q      <= is_busy(state_d);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_idx     = out_idx_q;
  assign out_re      = out_buf_re[out_idx_q*DATA_W +: DATA_W];
  assign out_im      = out_buf_im[out_idx_q*DATA_W +: DATA_W];
  assign fft_write   = fft_write_q;
  assign fft_start   = fft_start_q;
  assign fft_rst_n   = fft_rst_n_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_fft_8_seq.sv
// Directed bench for fft_8_seq with a behavioural FFT core model (real DFT,
// identity passthrough or stuck-not-ready).
module tb_fft_8_seq;

  localparam int W = 16;
  typedef logic [7:0][W-1:0] frame_t;

  typedef struct packed {
    frame_t in_re;
    frame_t in_im;
    frame_t exp_re;
    frame_t exp_im;
    logic   use_dft;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_re = '0;
  logic [W-1:0]  in_im = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_re, out_im;
  logic [2:0]    out_idx;
  logic          out_last;
  logic          fft_rst_n, fft_write, fft_start;
  logic [8*W-1:0] fft_in_re, fft_in_im;
  logic          fft_ready;
  logic [8*W-1:0] fft_out_re, fft_out_im;
  logic          busy, err_timeout;
  logic [15:0]   frame_cnt;

  fft_8_seq #(.DATA_W(W), .TIMEOUT(15)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .fft_rst_n  (fft_rst_n),
    .fft_write  (fft_write),
    .fft_start  (fft_start),
    .fft_in_re  (fft_in_re),
    .fft_in_im  (fft_in_im),
    .fft_ready  (fft_ready),
    .fft_out_re (fft_out_re),
    .fft_out_im (fft_out_im),
    .busy       (busy),
    .err_timeout(err_timeout),
    .frame_cnt  (frame_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- FFT core model ----------------
  bit            use_dft = 1'b1;
  bit            core_stuck = 1'b0;
  logic          core_ready = 1'b0;
  logic [3:0]    core_cnt = '0;
  logic [8*W-1:0] lat_re = '0, lat_im = '0;
  logic [8*W-1:0] core_out_re = '0, core_out_im = '0;

  function automatic logic [8*W-1:0] dft(input logic [8*W-1:0] xr, input logic [8*W-1:0] xi,
                                         input bit want_im);
    logic [8*W-1:0] r;
    real sr, si, a, vr, vi, v;
    int  t, q;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 8; n++) begin
        a  = -2.0 * 3.14159265358979 * real'(k * n) / 8.0;
        t  = $signed(xr[n*W +: W]);
        vr = real'(t);
        t  = $signed(xi[n*W +: W]);
        vi = real'(t);
        sr = sr + vr * $cos(a) - vi * $sin(a);
        si = si + vr * $sin(a) + vi * $cos(a);
      end
      v = want_im ? si : sr;
      q = (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
      r[k*W +: W] = q[W-1:0];
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    if (!fft_rst_n) begin
      core_ready <= 1'b0;
      core_cnt   <= '0;
    end else if (fft_write) begin
      lat_re   <= fft_in_re;
      lat_im   <= fft_in_im;
      core_cnt <= '0;
    end else if (fft_start && !core_stuck && !core_ready) begin
      core_cnt <= core_cnt + 4'd1;
      if (core_cnt == 4'd2) begin
        core_ready  <= 1'b1;
        core_out_re <= use_dft ? dft(lat_re, lat_im, 1'b0) : lat_re;
        core_out_im <= use_dft ? dft(lat_re, lat_im, 1'b1) : lat_im;
      end
    end
  end

  assign fft_ready  = core_ready;
  assign fft_out_re = core_out_re;
  assign fft_out_im = core_out_im;

  // ---------------- always-on protocol monitors ----------------
  always @(negedge CLK) begin
    if (!RST && fft_write && fft_start) begin
      errors++;
      $display("FAIL write_start_overlap: got 1 expected 0");
    end
    if (!RST && in_ready && (out_valid || busy)) begin
      errors++;
      $display("FAIL load_drain_overlap: got 1 expected 0");
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  // Feeds 8 samples; if abort_at < 8, raises abort together with that beat and returns.
  task automatic load_frame(input frame_t re, input frame_t im, input int abort_at, input string tag);
    int beat  = 0;
    int guard = 0;
    while (beat < 8 && guard < 200) begin
      @(negedge CLK);
      guard++;
      if (in_ready) begin
        in_valid = 1'b1;
        in_re    = re[beat];
        in_im    = im[beat];
        if (beat == abort_at) begin
          abort = 1'b1;
          @(negedge CLK);
          abort    = 1'b0;
          in_valid = 1'b0;
          check({tag, "_abort_in_ready"}, in_ready, 1'b0);
          check({tag, "_abort_fft_rst_n"}, fft_rst_n, 1'b0);
          check({tag, "_abort_busy"}, busy, 1'b0);
          return;
        end
        beat++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge CLK);
    in_valid = 1'b0;
    check({tag, "_load_beats"}, beat, 8);
    check({tag, "_wr_follows"}, fft_write, 1'b1);
    check({tag, "_wr_busy"}, busy, 1'b1);
    check({tag, "_wr_in_ready"}, in_ready, 1'b0);
    check({tag, "_wr_fft_in_re"}, fft_in_re, re);
    check({tag, "_wr_fft_in_im"}, fft_in_im, im);
  endtask

  // Waits for the result, then consumes 8 beats (optionally toggling out_ready).
  task automatic drain_frame(input frame_t er, input frame_t ei, input bit stall,
                             input int exp_frames, input string tag);
    int beat  = 0;
    int guard = 0;
    bit seen = 0, prev_rdy = 0, rdy = 0;
    out_ready = 1'b1;
    while (!seen && guard < 100) begin
      @(negedge CLK);
      guard++;
      if (out_valid) seen = 1;
      else prev_rdy = fft_ready && fft_start;
    end
    check({tag, "_first_valid"}, seen, 1'b1);
    check({tag, "_latency"}, prev_rdy, 1'b1);
    guard = 0;
    rdy   = 1'b0;
    while (seen && beat < 8 && guard < 100) begin
      out_ready = stall ? rdy : 1'b1;
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_idx"}, out_idx, beat[2:0]);
      check({tag, "_re"}, out_re, er[beat]);
      check({tag, "_im"}, out_im, ei[beat]);
      check({tag, "_last"}, out_last, (beat == 7));
      if (out_valid && out_ready) beat++;
      rdy = !rdy;
      if (beat < 8) begin
        @(negedge CLK);
        guard++;
      end
    end
    check({tag, "_beats"}, beat, 8);
    @(negedge CLK);
    out_ready = 1'b0;
    check({tag, "_valid_after"}, out_valid, 1'b0);
    check({tag, "_frame_cnt"}, frame_cnt, exp_frames[15:0]);
  endtask

  // ---------------- test sequence ----------------
  vec_t   vecs[5];
  frame_t ramp_re, ramp_im, alt_re, alt_im;
  int     frames = 0;
  int     n_start, n_valid;

  initial begin
    // Directed vectors with hand-computed expectations.
    for (int i = 0; i < 5; i++) vecs[i] = '0;
    vecs[0].use_dft = 1'b1;                     // impulse: flat spectrum of 100
    vecs[0].in_re[0] = 16'd100;
    for (int k = 0; k < 8; k++) vecs[0].exp_re[k] = 16'd100;
    vecs[1].use_dft = 1'b1;                     // DC of 10: bin 0 = 80
    for (int k = 0; k < 8; k++) vecs[1].in_re[k] = 16'd10;
    vecs[1].exp_re[0] = 16'd80;
    vecs[2].use_dft = 1'b1;                     // +5/-5 alternating: bin 4 = 40
    for (int k = 0; k < 8; k++) vecs[2].in_re[k] = k[0] ? 16'hFFFB : 16'd5;
    vecs[2].exp_re[4] = 16'd40;
    vecs[3].use_dft = 1'b1;                     // imaginary impulse -7: flat -7j
    vecs[3].in_im[0] = 16'hFFF9;
    for (int k = 0; k < 8; k++) vecs[3].exp_im[k] = 16'hFFF9;
    vecs[4].use_dft = 1'b0;                     // identity core: slot ordering, extremes
    vecs[4].in_re = {16'd8, 16'd7, 16'h7FFF, 16'h8000, 16'd4, 16'd300, 16'hFFFE, 16'd1};
    vecs[4].in_im = {16'd4000, 16'd3000, 16'd2000, 16'd1000, 16'd0, 16'hFC18, 16'hF830, 16'hF448};
    vecs[4].exp_re = {16'd8, 16'd7, 16'h7FFF, 16'h8000, 16'd4, 16'd300, 16'hFFFE, 16'd1};
    vecs[4].exp_im = {16'd4000, 16'd3000, 16'd2000, 16'd1000, 16'd0, 16'hFC18, 16'hF830, 16'hF448};

    for (int k = 0; k < 8; k++) begin
      ramp_re[k] = 16'(k * 11 + 1);
      ramp_im[k] = 16'(16'h8000 + k * 3);
      alt_re[k]  = 16'(100 - k * 25);
      alt_im[k]  = 16'(k * 7);
    end

    // Reset values while RST is held.
    repeat (3) @(negedge CLK);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_idx", out_idx, 3'd0);
    check("rst_fft_write", fft_write, 1'b0);
    check("rst_fft_start", fft_start, 1'b0);
    check("rst_fft_rst_n", fft_rst_n, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_in_buf", fft_in_re, 128'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_fft_rst_n", fft_rst_n, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      use_dft = vecs[i].use_dft;
      load_frame(vecs[i].in_re, vecs[i].in_im, 8, $sformatf("vec%0d", i));
      frames++;
      drain_frame(vecs[i].exp_re, vecs[i].exp_im, 1'b0, frames, $sformatf("vec%0d", i));
    end

    // Core never ready: timeout after exactly 15 RUN cycles, frame dropped.
    use_dft    = 1'b0;
    core_stuck = 1'b1;
    load_frame(ramp_re, ramp_im, 8, "tmo");
    n_start = 0;
    n_valid = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (out_valid) n_valid++;
      if (fft_start) n_start++;
      else if (n_start > 0) break;
    end
    check("tmo_run_cycles", n_start, 15);
    check("tmo_no_valid", n_valid, 0);
    check("tmo_err", err_timeout, 1'b1);
    check("tmo_clr_fft_rst_n", fft_rst_n, 1'b0);
    check("tmo_clr_in_ready", in_ready, 1'b0);
    @(negedge CLK);
    check("tmo_fft_rst_n_one_cycle", fft_rst_n, 1'b1);
    check("tmo_in_ready_again", in_ready, 1'b1);
    check("tmo_frame_cnt", frame_cnt, frames[15:0]);
    core_stuck = 1'b0;

    // Back-pressure: out_ready toggles every cycle during drain.
    load_frame(ramp_re, ramp_im, 8, "stall");
    frames++;
    drain_frame(ramp_re, ramp_im, 1'b1, frames, "stall");
    check("err_sticky", err_timeout, 1'b1);

    // Abort together with the 5th input beat, then a clean frame.
    load_frame(ramp_re, ramp_im, 4, "abort");
    load_frame(alt_re, alt_im, 8, "post_abort");
    frames++;
    drain_frame(alt_re, alt_im, 1'b0, frames, "post_abort");

    // Reset during drain beat 3.
    load_frame(ramp_re, ramp_im, 8, "rstd");
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (out_valid && out_idx == 3'd3) break;
    end
    check("rstd_at_beat3", out_idx, 3'd3);
    RST = 1'b1;
    @(negedge CLK);
    check("rstd_out_valid", out_valid, 1'b0);
    check("rstd_out_idx", out_idx, 3'd0);
    check("rstd_out_last", out_last, 1'b0);
    check("rstd_in_ready", in_ready, 1'b0);
    check("rstd_busy", busy, 1'b0);
    check("rstd_fft_rst_n", fft_rst_n, 1'b0);
    check("rstd_err", err_timeout, 1'b0);
    check("rstd_frame_cnt", frame_cnt, 16'd0);
    check("rstd_in_buf", {fft_in_re, fft_in_im} == '0, 1'b1);
    check("rstd_out_data", {out_re, out_im}, 32'd0);
    RST = 1'b0;
    n_valid = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (out_valid) n_valid++;
    end
    check("rstd_no_valid", n_valid, 0);
    load_frame(alt_re, alt_im, 8, "rstd_new");
    drain_frame(alt_re, alt_im, 1'b0, 1, "rstd_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
